reg_m: RTL and testbench
========================

Name: reg_m

Overview:
- Execute-to-Memory pipeline register with a valid/ready handshake and a 2-entry skid buffer.
- Captures the Execute stage result, the store data and the control/commit bundles carried by the Decode-to-Execute register. Presents them to the Memory stage.
- Back-pressure from Memory never has a combinational path to Execute.
- Flush input kills in-flight entries (trap/exception redirect).

Parameters:
- XLEN, 64, data/PC width
- LS_W, 11, load/store info width
- OP_W, 12, opcode info width
- COMMIT_W, 161, commit bundle width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- regM_i_flush  in  1  kill all held entries and the incoming one
- execute_i_valid  in  1  Execute presents a valid instruction
- regM_o_ready  out  1  reg_m can accept this cycle (registered)
- execute_i_alu_result  in  XLEN  ALU result / effective address
- execute_i_store_data  in  XLEN  rs2 value for stores
- regE_i_pc  in  XLEN  instruction PC
- regE_i_rd  in  5  destination register
- regE_i_reg_wen  in  1  register write enable
- regE_i_load_store_info  in  LS_W  access type/size
- regE_i_opcode_info  in  OP_W  opcode class
- regE_i_commit_info  in  COMMIT_W  commit/trace bundle
- memory_i_ready  in  1  Memory stage accepts the head entry
- regM_o_valid  out  1  head entry valid
- regM_o_alu_result, regM_o_store_data, regM_o_pc  out  XLEN  head payload
- regM_o_rd  out  5; regM_o_reg_wen  out  1; regM_o_load_store_info  out  LS_W; regM_o_opcode_info  out  OP_W; regM_o_commit_info  out  COMMIT_W  head payload

Behaviour:
- Clocking and reset: one clock (clk). rst is synchronous and active-high.
- Reset values: all valid bits are 0 and all payload registers are 0. regM_o_valid=0, regM_o_ready=1, and every payload output reads 0.
- Storage:
  - main slot (drives outputs) and skid slot, each holding valid + payload.
  - Payload = {alu_result, store_data, pc, rd, reg_wen, ls_info, op_info, commit_info}.
- Handshake signals:
  - accept = execute_i_valid & regM_o_ready.
  - fire = regM_o_valid & memory_i_ready.
  - regM_o_ready = !skid_valid, taken from a flop with no comb dependence on memory_i_ready.
  - regM_o_valid = main_valid.
  - regM_o_reg_wen = main_valid & main.reg_wen, so a bubble never writes the register file.
  - Other outputs come straight from the main payload.
- Latency: 1 cycle (accept at edge N, visible at output after edge N). Full throughput when memory_i_ready stays high.
- Transitions (evaluated when there is no flush):
  - Main empty: on accept, load main. The skid is necessarily empty.
  - Main full, fire, skid full: skid moves to main and the skid clears. No accept is possible (ready=0).
  - Main full, fire, skid empty: on accept, load main with the new entry; otherwise main_valid goes to 0.
  - Main full, no fire, accept: load skid, so ready=0 next cycle.
  - Main full, no fire, no accept: hold.
- Payload stability: while regM_o_valid=1 and memory_i_ready=0, all outputs stay stable.
- Ordering: strictly FIFO. The skid entry is always older than any later accept.
- Flush:
  - regM_i_flush=1 clears main_valid and skid_valid at the next edge.
  - The same-cycle accept is dropped, and flush wins over fire/accept.
  - regM_o_ready=1 the next cycle.
  - Payload registers may keep stale values but are masked by valid/reg_wen.
- Reset mid-transfer: same as flush and additionally zeroes the payload.
- Execute-side contract: once execute_i_valid is asserted it need not be held. reg_m samples only on accept.

Decomposition:
- Shared package (rv64_pipe_pkg): width constants XLEN/LS_W/OP_W/COMMIT_W and a packed exe_mem_payload_t struct, reused by reg_m and the Memory stage.
- One generic sub-module, pipe_skid_buf (parameter W):
  - Contains the two-slot valid/ready logic plus flush.
  - reg_m instantiates it with W=$bits(exe_mem_payload_t) and does the pack/unpack and reg_wen gating.

Test Plan:
- Streaming: memory_i_ready=1, pc=0x8000_0000, 0x8000_0004, ... accepted every cycle -> each appears exactly 1 cycle later, ready stays 1, no drops.
- Stall:
  - Hold memory_i_ready=0 after an entry with pc=0x100 -> entry pc=0x104 is accepted into the skid, then ready=0.
  - pc=0x108 is held off and outputs stay at 0x100.
  - Releasing ready -> 0x100, 0x104, 0x108 emerge in order.
- Flush while both slots are full and execute_i_valid=1 (pc=0x200) -> next cycle valid=0, reg_wen=0, ready=1, and 0x200 never appears.
- Bubble masking: flush an entry whose rd=5 and reg_wen=1 -> regM_o_reg_wen=0 from the cycle after the flush onward.
- Reset asserted with the skid full and memory_i_ready=1 -> the following cycle has all outputs 0 and ready=1, and no entry fires after reset.
- Random valid/ready over 10k cycles against a scoreboard FIFO -> zero mismatches, and regM_o_ready never depends combinationally on memory_i_ready.

Source files
------------

// File: rtl/rv64_pipe_pkg.sv
// Shared pipeline widths and the Execute-to-Memory payload bundle.
// Used by reg_m and by the Memory stage that consumes its outputs.
package rv64_pipe_pkg;

    localparam int XLEN     = 64;
    localparam int LS_W     = 11;
    localparam int OP_W     = 12;
    localparam int COMMIT_W = 161;

    typedef struct packed {
        logic [XLEN-1:0]     alu_result;
        logic [XLEN-1:0]     store_data;
        logic [XLEN-1:0]     pc;
        logic [4:0]          rd;
        logic                reg_wen;
        logic [LS_W-1:0]     ls_info;
        logic [OP_W-1:0]     op_info;
        logic [COMMIT_W-1:0] commit_info;
    } exe_mem_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-slot valid/ready pipeline register with flush.
// in_ready is a pure function of state, so out_ready never reaches it.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid;
    logic         skid_valid;
    logic [W-1:0] main_data;
    logic [W-1:0] skid_data;

    logic         main_valid_n;
    logic         skid_valid_n;
    logic [W-1:0] main_data_n;
    logic [W-1:0] skid_data_n;

    logic accept;
    logic fire;

    assign in_ready  = !skid_valid;
    assign accept    = in_valid & in_ready;
    assign fire      = main_valid & out_ready;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    always_comb begin
        main_valid_n = main_valid;
        skid_valid_n = skid_valid;
        main_data_n  = main_data;
        skid_data_n  = skid_data;
        if (flush) begin
            main_valid_n = 1'b0;
            skid_valid_n = 1'b0;
        end else if (!main_valid) begin
            if (accept) begin
                main_valid_n = 1'b1;
                main_data_n  = in_data;
            end
        end else if (fire) begin
            // The skid entry is older than anything accepted now.
            if (skid_valid) begin
                main_data_n  = skid_data;
                skid_valid_n = 1'b0;
            end else if (accept) begin
                main_data_n  = in_data;
            end else begin
                main_valid_n = 1'b0;
            end
        end else if (accept) begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            main_data  <= main_data_n;
            skid_data  <= skid_data_n;
        end
    end

endmodule

// File: rtl/reg_m.sv
// Execute-to-Memory pipeline register built on a two-slot skid buffer.
// Packs the Execute result and Decode/Execute bundles, gates reg_wen by valid.
module reg_m
    import rv64_pipe_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                regM_i_flush,
    input  logic                execute_i_valid,
    output logic                regM_o_ready,
    input  logic [XLEN-1:0]     execute_i_alu_result,
    input  logic [XLEN-1:0]     execute_i_store_data,
    input  logic [XLEN-1:0]     regE_i_pc,
    input  logic [4:0]          regE_i_rd,
    input  logic                regE_i_reg_wen,
    input  logic [LS_W-1:0]     regE_i_load_store_info,
    input  logic [OP_W-1:0]     regE_i_opcode_info,
    input  logic [COMMIT_W-1:0] regE_i_commit_info,
    input  logic                memory_i_ready,
    output logic                regM_o_valid,
    output logic [XLEN-1:0]     regM_o_alu_result,
    output logic [XLEN-1:0]     regM_o_store_data,
    output logic [XLEN-1:0]     regM_o_pc,
    output logic [4:0]          regM_o_rd,
    output logic                regM_o_reg_wen,
    output logic [LS_W-1:0]     regM_o_load_store_info,
    output logic [OP_W-1:0]     regM_o_opcode_info,
    output logic [COMMIT_W-1:0] regM_o_commit_info
);

    exe_mem_payload_t in_p;
    exe_mem_payload_t out_p;

    always_comb begin
        in_p             = '0;
        in_p.alu_result  = execute_i_alu_result;
        in_p.store_data  = execute_i_store_data;
        in_p.pc          = regE_i_pc;
        in_p.rd          = regE_i_rd;
        in_p.reg_wen     = regE_i_reg_wen;
        in_p.ls_info     = regE_i_load_store_info;
        in_p.op_info     = regE_i_opcode_info;
        in_p.commit_info = regE_i_commit_info;
    end

    pipe_skid_buf #(
        .W($bits(exe_mem_payload_t))
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (regM_i_flush),
        .in_valid  (execute_i_valid),
        .in_ready  (regM_o_ready),
        .in_data   (in_p),
        .out_valid (regM_o_valid),
        .out_ready (memory_i_ready),
        .out_data  (out_p)
    );

    assign regM_o_alu_result      = out_p.alu_result;
    assign regM_o_store_data      = out_p.store_data;
    assign regM_o_pc              = out_p.pc;
    assign regM_o_rd              = out_p.rd;
    // A flushed or empty slot must never write the register file.
    assign regM_o_reg_wen         = regM_o_valid & out_p.reg_wen;
    assign regM_o_load_store_info = out_p.ls_info;
    assign regM_o_opcode_info     = out_p.op_info;
    assign regM_o_commit_info     = out_p.commit_info;

endmodule

// File: tb/tb_reg_m.sv
// Self-checking bench for reg_m: vector table, corner sequences,
// and random traffic against a 2-deep FIFO reference model.
module tb_reg_m;
    import rv64_pipe_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                regM_i_flush;
    logic                execute_i_valid;
    logic                regM_o_ready;
    logic [XLEN-1:0]     execute_i_alu_result;
    logic [XLEN-1:0]     execute_i_store_data;
    logic [XLEN-1:0]     regE_i_pc;
    logic [4:0]          regE_i_rd;
    logic                regE_i_reg_wen;
    logic [LS_W-1:0]     regE_i_load_store_info;
    logic [OP_W-1:0]     regE_i_opcode_info;
    logic [COMMIT_W-1:0] regE_i_commit_info;
    logic                memory_i_ready;
    logic                regM_o_valid;
    logic [XLEN-1:0]     regM_o_alu_result;
    logic [XLEN-1:0]     regM_o_store_data;
    logic [XLEN-1:0]     regM_o_pc;
    logic [4:0]          regM_o_rd;
    logic                regM_o_reg_wen;
    logic [LS_W-1:0]     regM_o_load_store_info;
    logic [OP_W-1:0]     regM_o_opcode_info;
    logic [COMMIT_W-1:0] regM_o_commit_info;

    reg_m dut (
        .clk                    (clk),
        .rst                    (rst),
        .regM_i_flush           (regM_i_flush),
        .execute_i_valid        (execute_i_valid),
        .regM_o_ready           (regM_o_ready),
        .execute_i_alu_result   (execute_i_alu_result),
        .execute_i_store_data   (execute_i_store_data),
        .regE_i_pc              (regE_i_pc),
        .regE_i_rd              (regE_i_rd),
        .regE_i_reg_wen         (regE_i_reg_wen),
        .regE_i_load_store_info (regE_i_load_store_info),
        .regE_i_opcode_info     (regE_i_opcode_info),
        .regE_i_commit_info     (regE_i_commit_info),
        .memory_i_ready         (memory_i_ready),
        .regM_o_valid           (regM_o_valid),
        .regM_o_alu_result      (regM_o_alu_result),
        .regM_o_store_data      (regM_o_store_data),
        .regM_o_pc              (regM_o_pc),
        .regM_o_rd              (regM_o_rd),
        .regM_o_reg_wen         (regM_o_reg_wen),
        .regM_o_load_store_info (regM_o_load_store_info),
        .regM_o_opcode_info     (regM_o_opcode_info),
        .regM_o_commit_info     (regM_o_commit_info)
    );

    always #5 clk = ~clk;

    localparam int PW = $bits(exe_mem_payload_t);

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [63:0] pc;
        logic        mr;
        logic        exp_valid;
        logic [63:0] exp_pc;
        logic        exp_ready;
    } vec_t;

    vec_t tbl[8];
    exe_mem_payload_t q[$];

    task automatic chk(input string name, input logic [PW-1:0] act,
                       input logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exe_mem_payload_t rand_p();
        exe_mem_payload_t p;
        p.alu_result  = {$urandom, $urandom};
        p.store_data  = {$urandom, $urandom};
        p.pc          = {$urandom, $urandom};
        p.rd          = 5'($urandom);
        p.reg_wen     = 1'($urandom);
        p.ls_info     = LS_W'($urandom);
        p.op_info     = OP_W'($urandom);
        p.commit_info = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom};
        return p;
    endfunction

    function automatic exe_mem_payload_t pc_p(input logic [63:0] pc);
        exe_mem_payload_t p;
        p         = rand_p();
        p.pc      = pc;
        p.reg_wen = 1'b1;
        return p;
    endfunction

    function automatic exe_mem_payload_t got_p();
        exe_mem_payload_t p;
        p.alu_result  = regM_o_alu_result;
        p.store_data  = regM_o_store_data;
        p.pc          = regM_o_pc;
        p.rd          = regM_o_rd;
        p.reg_wen     = regM_o_reg_wen;
        p.ls_info     = regM_o_load_store_info;
        p.op_info     = regM_o_opcode_info;
        p.commit_info = regM_o_commit_info;
        return p;
    endfunction

    task automatic drive(input logic v, input exe_mem_payload_t p,
                         input logic mr, input logic fl, input logic r);
        execute_i_valid        = v;
        execute_i_alu_result   = p.alu_result;
        execute_i_store_data   = p.store_data;
        regE_i_pc              = p.pc;
        regE_i_rd              = p.rd;
        regE_i_reg_wen         = p.reg_wen;
        regE_i_load_store_info = p.ls_info;
        regE_i_opcode_info     = p.op_info;
        regE_i_commit_info     = p.commit_info;
        memory_i_ready         = mr;
        regM_i_flush           = fl;
        rst                    = r;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #1;
    endtask

    // Reference: a FIFO of at most two entries, flush/reset empty it.
    task automatic model_step(input logic v, input exe_mem_payload_t p,
                              input logic mr, input logic fl, input logic r);
        bit do_fire, do_acc;
        if (r || fl) begin
            q.delete();
        end else begin
            do_fire = (q.size() > 0) && mr;
            do_acc  = v && (q.size() < 2);
            if (do_fire) void'(q.pop_front());
            if (do_acc) q.push_back(p);
        end
    endtask

    initial begin
        exe_mem_payload_t p, e;
        logic [63:0] prev_pc;
        logic v, mr, fl, r, rdy0;

        tbl[0] = '{1'b1, 64'h100, 1'b0, 1'b0, 64'h0,   1'b1};
        tbl[1] = '{1'b1, 64'h104, 1'b0, 1'b1, 64'h100, 1'b1};
        tbl[2] = '{1'b1, 64'h108, 1'b0, 1'b1, 64'h100, 1'b0};
        tbl[3] = '{1'b1, 64'h108, 1'b0, 1'b1, 64'h100, 1'b0};
        tbl[4] = '{1'b1, 64'h108, 1'b1, 1'b1, 64'h100, 1'b0};
        tbl[5] = '{1'b1, 64'h108, 1'b1, 1'b1, 64'h104, 1'b1};
        tbl[6] = '{1'b0, 64'h0,   1'b1, 1'b1, 64'h108, 1'b1};
        tbl[7] = '{1'b0, 64'h0,   1'b1, 1'b0, 64'h0,   1'b1};

        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        do_reset();
        chk("reset_valid", PW'(regM_o_valid), PW'(1'b0));
        chk("reset_ready", PW'(regM_o_ready), PW'(1'b1));
        chk("reset_payload", PW'(got_p()), '0);

        // Streaming at full throughput.
        prev_pc = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, pc_p(64'h8000_0000 + 64'(4 * i)), 1'b1, 1'b0, 1'b0);
            #1;
            chk("stream_ready", PW'(regM_o_ready), PW'(1'b1));
            if (i > 0) begin
                chk("stream_valid", PW'(regM_o_valid), PW'(1'b1));
                chk("stream_pc", PW'(regM_o_pc), PW'(prev_pc));
            end
            prev_pc = 64'h8000_0000 + 64'(4 * i);
            @(posedge clk);
        end
        @(negedge clk);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
        #1;
        chk("stream_last_pc", PW'(regM_o_pc), PW'(prev_pc));
        @(posedge clk);

        // Stall / skid table.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            drive(tbl[i].v, pc_p(tbl[i].pc), tbl[i].mr, 1'b0, 1'b0);
            #1;
            chk($sformatf("tbl%0d_valid", i), PW'(regM_o_valid),
                PW'(tbl[i].exp_valid));
            chk($sformatf("tbl%0d_ready", i), PW'(regM_o_ready),
                PW'(tbl[i].exp_ready));
            chk($sformatf("tbl%0d_wen", i), PW'(regM_o_reg_wen),
                PW'(tbl[i].exp_valid));
            if (tbl[i].exp_valid)
                chk($sformatf("tbl%0d_pc", i), PW'(regM_o_pc),
                    PW'(tbl[i].exp_pc));
            @(posedge clk);
        end

        // Flush with both slots full and a new entry offered.
        do_reset();
        drive(1'b1, pc_p(64'h1F0), 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, pc_p(64'h1F4), 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, pc_p(64'h200), 1'b1, 1'b1, 1'b0);
        #1;
        chk("full_ready", PW'(regM_o_ready), PW'(1'b0));
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            #1;
            chk("flush_valid", PW'(regM_o_valid), PW'(1'b0));
            chk("flush_wen", PW'(regM_o_reg_wen), PW'(1'b0));
            chk("flush_ready", PW'(regM_o_ready), PW'(1'b1));
            @(posedge clk);
        end

        // Bubble masking of reg_wen after a flush.
        @(negedge clk);
        p = pc_p(64'h300);
        p.rd = 5'd5;
        drive(1'b1, p, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
        #1;
        chk("bubble_pre_wen", PW'(regM_o_reg_wen), PW'(1'b1));
        chk("bubble_pre_rd", PW'(regM_o_rd), PW'(5'd5));
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
            #1;
            chk("bubble_wen", PW'(regM_o_reg_wen), PW'(1'b0));
            @(posedge clk);
        end

        // Reset while the skid is full and Memory is ready.
        @(negedge clk);
        drive(1'b1, rand_p(), 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, rand_p(), 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
            #1;
            chk("rst_mid_valid", PW'(regM_o_valid), PW'(1'b0));
            chk("rst_mid_ready", PW'(regM_o_ready), PW'(1'b1));
            chk("rst_mid_payload", PW'(got_p()), '0);
            @(posedge clk);
        end

        // Random traffic against the FIFO model.
        do_reset();
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            if (c > 0) @(negedge clk);
            v  = ($urandom_range(0, 3) != 0);
            mr = ($urandom_range(0, 2) != 0);
            fl = ($urandom_range(0, 63) == 0);
            r  = ($urandom_range(0, 499) == 0);
            p  = rand_p();
            drive(v, p, mr, fl, r);
            #1;
            chk("rnd_valid", PW'(regM_o_valid), PW'(q.size() > 0));
            chk("rnd_ready", PW'(regM_o_ready), PW'(q.size() < 2));
            if (q.size() > 0) begin
                e = q[0];
                chk("rnd_payload", PW'(got_p()), PW'(e));
            end else begin
                chk("rnd_bubble_wen", PW'(regM_o_reg_wen), PW'(1'b0));
            end
            rdy0 = regM_o_ready;
            memory_i_ready = ~mr;
            #1;
            chk("rnd_ready_comb", PW'(regM_o_ready), PW'(rdy0));
            memory_i_ready = mr;
            @(posedge clk);
            model_step(v, p, mr, fl, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
